// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch front end: state encoding,
// reset PC and the all-zero bubble word that IF/ID treats as a no-op.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] BUBBLE_INSTR     = '0;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
        return target & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Fetch front end: owns the PC, keeps one imem request in flight and feeds
// {pc_out, instr_out} to IF/ID, with bubbles whenever nothing is ready.
//
//   state | meaning
//   IDLE  | first cycle after reset, no request yet
//   REQ   | imem_req asserted at pc, waiting for imem_gnt
//   WAIT  | request granted, waiting for imem_rvalid (kill = drop it)
//   HOLD  | captured instruction held on the outputs during stall
module imem_fetch_ctrl
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] BUBBLE   = BUBBLE_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            kill, kill_nxt;
    logic            capture;
    logic            hold_out;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        capture   = 1'b0;
        hold_out  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = align_pc(redirect_target);
                    // the old address was accepted, so its response must be dropped
                    if (imem_gnt) begin
                        state_nxt = WAIT;
                        kill_nxt  = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = align_pc(redirect_target);
                    if (imem_rvalid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        pc_nxt    = pc + XLEN'(4);
                        state_nxt = stall ? HOLD : REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = align_pc(redirect_target);
                    state_nxt = REQ;
                end else if (stall) begin
                    hold_out = 1'b1;
                end else begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture shows for exactly one cycle unless the stall keeps it in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out      <= '0;
            instr_out   <= BUBBLE;
            instr_valid <= 1'b0;
        end else if (capture) begin
            pc_out      <= pc;
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (!hold_out) begin
            instr_out   <= BUBBLE;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level fetch model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    imem_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instr_out       (instr_out),
        .instr_valid     (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fetch model: booted / outstanding / stale / holding flags
    logic        m_booted, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_pcout, m_instr;
    logic        m_valid;

    // memory model
    logic        mem_busy;
    int          mem_cnt;
    int          lat_lo, lat_hi, gnt_pct;
    logic [31:0] last_rdata;
    int          pulses;

    function automatic logic exp_req();
        return m_booted && !m_out && !m_hold;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("imem_req",    32'(imem_req),    32'(exp_req()));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_out",   instr_out,        m_instr);
        chk("pc_out",      pc_out,           m_pcout);
    endtask

    task automatic model_reset();
        m_booted = 1'b0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_hold   = 1'b0;
        m_pc     = 32'h0;
        m_pcout  = 32'h0;
        m_instr  = 32'h0;
        m_valid  = 1'b0;
    endtask

    // rdm: 0 none, 1 always, 2 only with rvalid, 3 only while waiting without rvalid
    task automatic step(input int rdm, input logic [31:0] tgt, input logic st);
        logic rv, g, rd;
        rv = 1'b0;
        g  = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rv       = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (exp_req() && !mem_busy && ($urandom_range(99) < 32'(gnt_pct))) begin
            g        = 1'b1;
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(32'(lat_hi), 32'(lat_lo))) - 1;
        end
        case (rdm)
            1:       rd = 1'b1;
            2:       rd = rv;
            3:       rd = m_out && !rv;
            default: rd = 1'b0;
        endcase
        imem_rvalid     = rv;
        imem_rdata      = $urandom;
        imem_gnt        = g;
        redirect_valid  = rd;
        redirect_target = tgt;
        stall           = st;
        if (rv) last_rdata = imem_rdata;

        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (rd) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (m_out) begin
                if (rv) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end else if (m_hold) begin
                m_hold = 1'b0;
            end else if (g) begin
                m_out   = 1'b1;
                m_stale = 1'b1;
            end
        end else if (m_out && rv) begin
            m_out = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
                m_valid = 1'b0;
                m_instr = 32'h0;
            end else begin
                m_pcout = m_pc;
                m_instr = imem_rdata;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_hold  = st;
            end
        end else if (m_hold && st) begin
            m_hold = 1'b1;
        end else begin
            m_hold  = 1'b0;
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (!m_out && g) m_out = 1'b1;
        end

        @(negedge clk);
        check_outputs();
        if (instr_valid) pulses++;
    endtask

    initial begin
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        stall           = 1'b0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        mem_busy        = 1'b0;
        mem_cnt         = 0;
        last_rdata      = 32'h0;
        pulses          = 0;
        model_reset();

        #1;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_addr",  imem_addr,        32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr_out,        32'h0);
        chk("rst_pcout", pc_out,           32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_outputs();

        // 1: immediate grant, response two cycles after grant
        gnt_pct = 100; lat_lo = 2; lat_hi = 2;
        repeat (9) step(0, 32'h0, 1'b0);
        chk("t1_pulses", 32'(pulses), 32'd2);
        chk("t1_addr",   imem_addr,   32'h8);

        // 2: stall from the capture of pc=8 for three cycles
        step(0, 32'h0, 1'b1);
        chk("t2_valid0", 32'(instr_valid), 32'h1);
        chk("t2_pcout",  pc_out,           32'h8);
        chk("t2_instr",  instr_out,        last_rdata);
        step(0, 32'h0, 1'b1);
        step(0, 32'h0, 1'b1);
        chk("t2_valid2", 32'(instr_valid), 32'h1);
        chk("t2_noreq",  32'(imem_req),    32'h0);
        step(0, 32'h0, 1'b0);
        chk("t2_req",    32'(imem_req),    32'h1);
        chk("t2_addr",   imem_addr,        32'hC);

        // 3: redirect while waiting, stale response two cycles later
        lat_lo = 3; lat_hi = 3;
        step(0, 32'h0, 1'b0);
        step(3, 32'h100, 1'b0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        chk("t3_valid", 32'(instr_valid), 32'h0);
        chk("t3_req",   32'(imem_req),    32'h1);
        chk("t3_addr",  imem_addr,        32'h100);

        // 4: redirect in the same cycle as the response
        lat_lo = 2; lat_hi = 2;
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        step(2, 32'h203, 1'b0);
        chk("t4_valid", 32'(instr_valid), 32'h0);
        chk("t4_addr",  imem_addr,        32'h200);
        chk("t4_req",   32'(imem_req),    32'h1);

        // 5: redirect and stall together while holding
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b1);
        chk("t5_hold",  32'(instr_valid), 32'h1);
        step(1, 32'h300, 1'b1);
        chk("t5_valid", 32'(instr_valid), 32'h0);
        chk("t5_addr",  imem_addr,        32'h300);
        chk("t5_req",   32'(imem_req),    32'h1);

        // 6: redirect granted in REQ, fetch at top of memory, wrap, reset mid-WAIT
        step(1, 32'hFFFF_FFFC, 1'b0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        chk("t6_pcout", pc_out,    32'hFFFF_FFFC);
        chk("t6_wrap",  imem_addr, 32'h0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        lat_lo = 3; lat_hi = 3;
        step(0, 32'h0, 1'b0);
        chk("t6_wait_addr", imem_addr, 32'h4);
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_req",   32'(imem_req),    32'h0);
        chk("t6_rst_addr",  imem_addr,        32'h0);
        chk("t6_rst_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check_outputs();
        gnt_pct = 0;
        step(0, 32'h0, 1'b0);
        chk("t6_req_after", 32'(imem_req), 32'h1);
        chk("t6_addr_after", imem_addr,    32'h0);
        step(0, 32'h0, 1'b0);
        step(0, 32'h0, 1'b0);
        chk("t6_stale", 32'(instr_valid), 32'h0);

        // random traffic
        gnt_pct = 60; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            int          mode;
            t    = $urandom;
            mode = ($urandom_range(99) < 12) ? int'($urandom_range(3, 1)) : 0;
            step(mode, t, ($urandom_range(99) < 30));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
